// File: rtl/window_scan_ctrl.sv
// Kernel-window scan sequencer: walks orow/ocol/kr/kc and issues one tap per accepted cycle.
// Optional macro WINDOW_SCAN_ABORT_EN adds an abort input that ends a scan early.
module window_scan_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5,
  parameter int AW    = 10,
  localparam int OW   = IMG_W - K + 1,
  localparam int OH   = IMG_H - K + 1,
  localparam int WW   = (K * K > 1) ? $clog2(K * K) : 1,
  localparam int RW   = (OH > 1) ? $clog2(OH) : 1,
  localparam int CW   = (OW > 1) ? $clog2(OW) : 1,
  localparam int KW   = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef WINDOW_SCAN_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          tap_valid,
  input  logic          tap_ready,
  output logic [AW-1:0] tap_addr,
  output logic [WW-1:0] tap_widx,
  output logic          tap_first,
  output logic          tap_last,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [KW-1:0] kc;
  logic [KW-1:0] kr;
  logic [AW-1:0] base;      // address of the window's top-left pixel
  logic [AW-1:0] row_base;  // base + kr*IMG_W
  logic          abort_req;
  logic          kc_end;
  logic          kr_end;
  logic          col_end;
  logic          row_end;
  logic          scan_end;

`ifdef WINDOW_SCAN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign kc_end   = (kc == KW'(K - 1));
  assign kr_end   = (kr == KW'(K - 1));
  assign col_end  = (out_col == CW'(OW - 1));
  assign row_end  = (out_row == RW'(OH - 1));
  assign scan_end = kc_end && kr_end && col_end && row_end;

  // Handshake: a tap transfers on any edge where tap_valid && tap_ready; tap
  // outputs come only from registers, so they hold while tap_ready is low.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign tap_valid = (state == S_RUN);
  assign tap_first = tap_valid && (kr == '0) && (kc == '0);
  assign tap_last  = tap_valid && kc_end && kr_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      kc       <= '0;
      kr       <= '0;
      out_row  <= '0;
      out_col  <= '0;
      tap_widx <= '0;
      tap_addr <= '0;
      base     <= '0;
      row_base <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            kc       <= '0;
            kr       <= '0;
            out_row  <= '0;
            out_col  <= '0;
            tap_widx <= '0;
            tap_addr <= '0;
            base     <= '0;
            row_base <= '0;
          end
        end
        S_RUN: begin
          if (abort_req) begin
            state <= S_DONE;
          end else if (tap_ready) begin
            if (scan_end) begin
              state <= S_DONE;
            end else if (!kc_end) begin
              kc       <= kc + KW'(1);
              tap_widx <= tap_widx + WW'(1);
              tap_addr <= tap_addr + AW'(1);
            end else if (!kr_end) begin
              kc       <= '0;
              kr       <= kr + KW'(1);
              tap_widx <= tap_widx + WW'(1);
              row_base <= row_base + AW'(IMG_W);
              tap_addr <= row_base + AW'(IMG_W);
            end else if (!col_end) begin
              kc       <= '0;
              kr       <= '0;
              tap_widx <= '0;
              out_col  <= out_col + CW'(1);
              base     <= base + AW'(1);
              row_base <= base + AW'(1);
              tap_addr <= base + AW'(1);
            end else begin
              // Last column is IMG_W-K, so adding K lands on the next row's column 0.
              kc       <= '0;
              kr       <= '0;
              tap_widx <= '0;
              out_col  <= '0;
              out_row  <= out_row + RW'(1);
              base     <= base + AW'(K);
              row_base <= base + AW'(K);
              tap_addr <= base + AW'(K);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Sequencer that scans a K×K kernel window across an IMG_W×IMG_H feature map and issues one tap per cycle to the MAC datapath: pixel address, weight index, output position and first/last tags. It sits between the top-level inference FSM and the convolution MAC/feature-map RAM. It replaces ad-hoc chains of cascaded modulo counters with one handshaked loop controller.

## Interface
- IMG_W, default 28: input map width in pixels.
- IMG_H, default 28: input map height in pixels.
- K, default 5: kernel size. Legal range is 1 ≤ K ≤ min(IMG_W, IMG_H).
- AW, default 10: pixel address width. Must satisfy IMG_W*IMG_H ≤ 2^AW.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse after the final tap is accepted.
- tap_valid  output  1  a tap is presented.
- tap_ready  input  1  the MAC accepts the tap this cycle.
- tap_addr  output  AW  pixel address = (orow+kr)*IMG_W + (ocol+kc).
- tap_widx  output  $clog2(K*K)  weight index = kr*K + kc.
- tap_first  output  1  kr==0 && kc==0; the MAC clears its accumulator.
- tap_last  output  1  kr==K-1 && kc==K-1; the MAC writes its result.
- out_row  output  $clog2(IMG_H-K+1)  current output row (orow).
- out_col  output  $clog2(IMG_W-K+1)  current output column (ocol).

## Operation
- Output grid: OW = IMG_W-K+1, OH = IMG_H-K+1. Stride is 1, with no padding.
- Loop nest, outermost to innermost: orow, ocol, kr, kc.
- States are IDLE, RUN and DONE.
- IDLE:
  - On start=1, clear all four counters and go to RUN.
- RUN:
  - tap_valid=1.
  - On tap_valid && tap_ready, advance kc.
  - kc wraps to 0 at K-1 and carries into kr.
  - kr wraps at K-1 and carries into ocol.
  - ocol wraps at OW-1 and carries into orow.
  - If the accepted tap has orow=OH-1, ocol=OW-1, kr=kc=K-1, go to DONE instead of advancing.
- DONE:
  - done=1 and tap_valid=0 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored, with no queuing.
- tap_addr is maintained incrementally: a window-base register plus a row-offset register, using adders only and no multipliers.
- All tap outputs, out_row and out_col are registered state or functions of registered counters only, never of tap_ready.

## Timing
- Reset values:
  - State is IDLE.
  - busy, done, tap_valid, tap_first and tap_last are 0.
  - tap_addr, tap_widx, out_row and out_col are 0.
- Start latency:
  - start sampled in cycle n gives tap_valid=1 in cycle n+1, with tap_addr=0, tap_widx=0 and tap_first=1.
- Backpressure:
  - While tap_valid && !tap_ready, every tap output holds stable.
  - tap_valid never deasserts in RUN.
- Throughput is one tap per cycle when tap_ready is held at 1.
- Full-scan timing with tap_ready=1:
  - A full scan takes OH*OW*K*K RUN cycles.
  - done follows in the next cycle.
  - IDLE follows in the cycle after that.
  - The earliest restart start is the cycle in which done is high plus 1, i.e. when the block is back in IDLE.
- rst in any state returns the block to IDLE and reset values on the next edge; an in-flight tap is dropped.
- K=1 case: tap_first and tap_last are both 1 on every tap.

## Configuration
- Macro WINDOW_SCAN_ABORT_EN.
- When defined:
  - An extra input port `abort` (1 bit) is present.
  - abort=1 in RUN goes to DONE on the next edge, with done=1 for one cycle; no further taps are issued.
  - The tap in that cycle is not counted, even if tap_ready=1.
  - abort is ignored in IDLE and DONE.
- When undefined:
  - The port is absent.
  - A scan runs only to completion or to rst.

## Test plan
- Basic scan, IMG_W=4, IMG_H=4, K=2, tap_ready=1, start pulse:
  - 36 taps on consecutive cycles.
  - First window addresses are 0, 1, 4, 5, with widx 0 to 3 and first/last on taps 1 and 4.
  - The last tap has addr 15, out_row=2, out_col=2.
  - done pulses exactly once, one cycle after the last tap.
- Backpressure, same configuration: tap_ready toggling pseudo-randomly at 50%.
  - The accepted tap sequence is identical to the basic scan (36 taps).
  - Outputs stay stable during every stall cycle.
- Start while busy: pulse start on the 10th tap and again in the done cycle.
  - Both are ignored and no second scan begins.
  - A start in the following IDLE cycle begins a new scan with addr 0.
- Reset mid-run: assert rst after 17 accepted taps.
  - The next cycle shows IDLE with all outputs 0.
  - A subsequent start restarts from addr 0, with no done from the aborted scan.
- Default parameters (28/28/5):
  - Exactly 24*24*25 = 14400 accepted taps.
  - Final tap addr is 783 (= 27*28+27) with tap_widx 24.
- With WINDOW_SCAN_ABORT_EN, assert abort on tap 5:
  - done in the next cycle with exactly 4 taps accepted.
  - IDLE in the cycle after that.
